mist1032isa_sync_fifo_reader: RTL and testbench
===============================================

# mist1032isa_sync_fifo_reader

Read-side consumer for the codebase's synchronous FIFO. It pops entries from the FIFO's show-ahead read port (empty flag, combinational head data, read-enable) and presents them to a downstream unit over a request/busy handshake. A two-entry output stage removes any combinational path from downstream `iBUSY` to the FIFO read enable, while sustaining one word per cycle. It sits between a FIFO instance and a pipeline stage or bus master consuming that FIFO.

## Interface
- `N`, default 16: data word width.
- `iCLOCK`  in  1  system clock, all state updates on rising edge.
- `inRESET`  in  1  asynchronous, active-low reset.
- `iREMOVE`  in  1  synchronous flush; drop all held words.
- `iFIFO_EMPTY`  in  1  FIFO empty flag; 1 = no valid head entry.
- `iFIFO_DATA`  in  N  FIFO head word; valid whenever `iFIFO_EMPTY`=0.
- `oFIFO_RD_EN`  out  1  pop strobe to the FIFO; one word is consumed per cycle high.
- `oREQ`  out  1  `oDATA` valid, offered downstream.
- `oDATA`  out  N  oldest held word.
- `iBUSY`  in  1  downstream cannot accept this cycle.
- `oHOLD_COUNT`  out  2  words held internally, 0..2.
- `oIDLE`  out  1  1 when holding 0 words and `iFIFO_EMPTY`=1.

## Operation
- Storage: head register `H` (N bits), tail register `T` (N bits), and state `{EMPTY, ONE, TWO}` encoded as hold count 0/1/2.
- `push` = `oFIFO_RD_EN`; `pop` = `oREQ & !iBUSY`.
- `oFIFO_RD_EN` = `!iFIFO_EMPTY & (state != TWO) & !iREMOVE`.
  - It is a function of registered state, `iFIFO_EMPTY` and `iREMOVE` only.
  - `iBUSY` has no combinational path to it.
- `oREQ` = `(state != EMPTY)`; `oDATA` = `H`.
- `oHOLD_COUNT` = state encoding; `oIDLE` = `(state == EMPTY) & iFIFO_EMPTY`.
- Transitions (no `iREMOVE`):
  - EMPTY: on push, `H` <= `iFIFO_DATA` and go to ONE. Otherwise stay. Pop is impossible (`oREQ`=0).
  - ONE, push and pop: `H` <= `iFIFO_DATA`, stay ONE.
  - ONE, push only: `T` <= `iFIFO_DATA`, go to TWO.
  - ONE, pop only: go to EMPTY; `H` keeps its stale value.
  - ONE, neither: hold.
  - TWO: push is impossible. On pop, `H` <= `T` and go to ONE. Otherwise hold.
- Order preserved: words leave in exactly FIFO pop order; no word dropped or duplicated.
- `iREMOVE`=1: next state EMPTY and `oFIFO_RD_EN`=0 that cycle.
  - A downstream pop in that cycle is still counted by downstream, but the block discards state regardless.
  - Callers assert `iREMOVE` on the FIFO at the same time.
- `iREMOVE` has priority over push/pop. `inRESET` has priority over everything.
- Width rules: `oHOLD_COUNT` never exceeds 2. Encoding 3 is unreachable; if entered, next state is EMPTY.

## Timing
- Reset values: state EMPTY, `H`=0, `T`=0.
  - Outputs during/after reset: `oREQ`=0, `oDATA`=0, `oHOLD_COUNT`=0, `oFIFO_RD_EN`=`!iFIFO_EMPTY`.
  - `oIDLE`=`iFIFO_EMPTY`.
- Reset is asynchronous: asserting `inRESET` mid-transfer clears state immediately, without waiting for a clock edge.
- Latency: the FIFO goes non-empty in cycle k, `oFIFO_RD_EN`=1 in cycle k, and `oREQ`=1 with that word from cycle k+1. Fall-through latency is 1 cycle.
- Throughput: with `iBUSY`=0 and the FIFO never empty, state stays ONE and one word transfers every cycle.
- Backpressure: with `iBUSY` held at 1, the block takes at most 2 words, then `oFIFO_RD_EN`=0 until a pop.
- Refill after pop from TWO: the cycle after the pop, state is ONE and `oFIFO_RD_EN` may reassert.
- `oDATA`/`oREQ` change only on clock edges (or reset). They stay stable while `oREQ=1 & iBUSY=1`.

## Test plan
- Reset: `inRESET`=0 with the FIFO holding 3 words -> `oREQ`=0, `oDATA`=0, `oHOLD_COUNT`=0, `oFIFO_RD_EN`=1; after release, word 0 appears on `oDATA` one cycle later.
- Streaming: write 0x0001..0x0010 to the FIFO with `iBUSY`=0 -> 16 consecutive cycles of `oREQ`=1, `oDATA` incrementing by 1, `oHOLD_COUNT`=1 throughout, then `oIDLE`=1.
- Backpressure: FIFO holds 0xA0..0xA3, `iBUSY`=1 -> exactly 2 `oFIFO_RD_EN` pulses, `oHOLD_COUNT`=2, `oDATA`=0xA0 stable. Release `iBUSY` -> outputs 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles.
- Alternating `iBUSY` (1,0,1,0…) with the FIFO continuously fed 0x100.. -> no loss or duplication; the output sequence equals the input sequence. Scoreboard checks 64 words.
- Flush: `oHOLD_COUNT`=2 (0x55, 0x66), pulse `iREMOVE` together with FIFO remove -> next cycle `oREQ`=0, `oHOLD_COUNT`=0, no `oFIFO_RD_EN` in the flush cycle; a new word 0x77 later appears first.
- Async reset mid-stream: drop `inRESET` between clock edges with `oHOLD_COUNT`=2 -> `oREQ`=0 and `oHOLD_COUNT`=0 before the next rising edge.

Source files
------------

// File: rtl/mist1032isa_sync_fifo_reader.sv
// mist1032isa_sync_fifo_reader
//
// Read-side consumer for the synchronous FIFO. Pops words from the FIFO's
// show-ahead read port and offers them downstream over a request/busy
// handshake. A two-word output stage (head H, tail T) keeps iBUSY out of the
// combinational cone of oFIFO_RD_EN while still moving one word per cycle.
//
// Handshake semantics:
//   Upstream (FIFO):   a word is consumed on every rising edge where
//                      oFIFO_RD_EN=1. oFIFO_RD_EN is only raised while
//                      iFIFO_EMPTY=0, so every pop takes a valid head word.
//   Downstream:        a word transfers on every rising edge where
//                      oREQ=1 and iBUSY=0. While oREQ=1 and iBUSY=1,
//                      oREQ/oDATA hold steady until the transfer happens.
//
// Ports:
//   iCLOCK       system clock, rising edge
//   inRESET      asynchronous active-low reset
//   iREMOVE      synchronous flush, drops all held words
//   iFIFO_EMPTY  FIFO empty flag
//   iFIFO_DATA   FIFO head word (valid when iFIFO_EMPTY=0)
//   oFIFO_RD_EN  FIFO pop strobe
//   oREQ         oDATA valid towards downstream
//   oDATA        oldest held word
//   iBUSY        downstream cannot accept this cycle
//   oHOLD_COUNT  words held internally (0..2); also the FSM state
//   oIDLE        nothing held and FIFO empty
module mist1032isa_sync_fifo_reader #(
  parameter int N = 16
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iREMOVE,
  input  logic         iFIFO_EMPTY,
  input  logic [N-1:0] iFIFO_DATA,
  output logic         oFIFO_RD_EN,
  output logic         oREQ,
  output logic [N-1:0] oDATA,
  input  logic         iBUSY,
  output logic [1:0]   oHOLD_COUNT,
  output logic         oIDLE
);

  // State encoding equals the number of held words.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ONE     = 2'd1,
    TWO     = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t       state, stateNext;
  logic [N-1:0] head, headNext;
  logic [N-1:0] tail, tailNext;
  logic         push;
  logic         pop;

  // Only registered state and FIFO/flush inputs feed the pop strobe; the
  // spare slot in ONE absorbs the word that would otherwise need iBUSY.
  // The unreachable encoding is excluded so a stray word is never popped
  // just to be thrown away by the recovery transition.
  assign push = !iFIFO_EMPTY && (state == EMPTY || state == ONE) && !iREMOVE;
  assign pop  = oREQ && !iBUSY;

  assign oFIFO_RD_EN = push;
  assign oREQ        = (state != EMPTY);
  assign oDATA       = head;
  assign oHOLD_COUNT = state;
  assign oIDLE       = (state == EMPTY) && iFIFO_EMPTY;

  always_comb begin
    stateNext = state;
    headNext  = head;
    tailNext  = tail;
    if (iREMOVE) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            headNext  = iFIFO_DATA;
            stateNext = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: headNext = iFIFO_DATA;
            2'b10: begin
              tailNext  = iFIFO_DATA;
              stateNext = TWO;
            end
            // H keeps its stale value; oREQ=0 masks it.
            2'b01: stateNext = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            headNext  = tail;
            stateNext = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= stateNext;
      head  <= headNext;
      tail  <= tailNext;
    end
  end

endmodule

// File: tb/tb_mist1032isa_sync_fifo_reader.sv
module tb_mist1032isa_sync_fifo_reader;

  localparam int N = 16;

  logic         iCLOCK;
  logic         inRESET;
  logic         iREMOVE;
  logic         iFIFO_EMPTY;
  logic [N-1:0] iFIFO_DATA;
  logic         oFIFO_RD_EN;
  logic         oREQ;
  logic [N-1:0] oDATA;
  logic         iBUSY;
  logic [1:0]   oHOLD_COUNT;
  logic         oIDLE;

  mist1032isa_sync_fifo_reader #(.N(N)) dut (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iREMOVE     (iREMOVE),
    .iFIFO_EMPTY (iFIFO_EMPTY),
    .iFIFO_DATA  (iFIFO_DATA),
    .oFIFO_RD_EN (oFIFO_RD_EN),
    .oREQ        (oREQ),
    .oDATA       (oDATA),
    .iBUSY       (iBUSY),
    .oHOLD_COUNT (oHOLD_COUNT),
    .oIDLE       (oIDLE)
  );

  // ---------------- clock / reset ----------------
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // ---------------- reference model ----------------
  // fifo_q : words sitting in the FIFO
  // exp_q  : every word written to the FIFO and not yet delivered, in order
  // held_n : words the reader holds (0..2)
  logic [N-1:0] fifo_q[$];
  logic [N-1:0] exp_q[$];
  int           held_n;

  int vec_cnt;
  int err_cnt;
  int rd_pulses;
  int delivered;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fifo_write(input logic [N-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drive_fifo();
    iFIFO_EMPTY = (fifo_q.size() == 0);
    iFIFO_DATA  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input logic busy, input logic remove);
    logic exp_rd, exp_req, take;
    iBUSY   = busy;
    iREMOVE = remove;
    drive_fifo();
    #1;
    exp_rd  = (fifo_q.size() != 0) && (held_n < 2) && !remove;
    exp_req = (held_n != 0);
    take    = exp_req && !busy;
    check("rd_en", oFIFO_RD_EN, exp_rd);
    check("req",   oREQ,        exp_req);
    check("hold",  oHOLD_COUNT, held_n);
    check("idle",  oIDLE,       (held_n == 0) && (fifo_q.size() == 0));
    if (exp_req && exp_q.size() != 0) check("data", oDATA, exp_q[0]);
    if (oFIFO_RD_EN) rd_pulses++;
    @(posedge iCLOCK);
    if (take) begin
      void'(exp_q.pop_front());
      delivered++;
      held_n--;
    end
    if (remove) begin
      fifo_q.delete();
      exp_q.delete();
      held_n = 0;
    end else if (exp_rd) begin
      void'(fifo_q.pop_front());
      held_n++;
    end
    @(negedge iCLOCK);
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    held_n = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rd_pulses = 0;
    delivered = 0;
    held_n    = 0;
    inRESET   = 1'b0;
    iREMOVE   = 1'b0;
    iBUSY     = 1'b0;
    drive_fifo();

    // Reset with three words waiting in the FIFO.
    @(negedge iCLOCK);
    fifo_write(16'h0C00);
    fifo_write(16'h0C01);
    fifo_write(16'h0C02);
    drive_fifo();
    #1;
    check("rst_req",   oREQ,        1'b0);
    check("rst_data",  oDATA,       16'h0000);
    check("rst_hold",  oHOLD_COUNT, 2'd0);
    check("rst_rd_en", oFIFO_RD_EN, 1'b1);
    check("rst_idle",  oIDLE,       1'b0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    cycle(1'b1, 1'b0);
    check("rst_first", oDATA, 16'h0C00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // Streaming 0x0001..0x0010 with no backpressure.
    for (int i = 1; i <= 16; i++) fifo_write(i[N-1:0]);
    delivered = 0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
    check("stream_cnt", delivered, 16);

    // Backpressure: four words, busy held high.
    for (int i = 0; i < 4; i++) fifo_write(16'h00A0 + i[N-1:0]);
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check("bp_pulses", rd_pulses, 2);
    check("bp_data",   oDATA,     16'h00A0);
    delivered = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    check("bp_cnt", delivered, 4);

    // Alternating busy with a continuously fed FIFO, 64 words.
    delivered = 0;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 400 && delivered < 64; c++) begin
        if (sent < 64 && fifo_q.size() < 3) begin
          fifo_write(16'h0100 + sent[N-1:0]);
          sent++;
        end
        cycle(c[0] == 1'b0, 1'b0);
      end
    end
    check("alt_cnt", delivered, 64);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // Flush with two held words.
    fifo_write(16'h0055);
    fifo_write(16'h0066);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    check("fl_hold", oHOLD_COUNT, 2'd2);
    fifo_write(16'h0099);
    cycle(1'b1, 1'b1);
    check("fl_req",  oREQ,        1'b0);
    check("fl_hold0", oHOLD_COUNT, 2'd0);
    cycle(1'b0, 1'b0);
    fifo_write(16'h0077);
    cycle(1'b1, 1'b0);
    check("fl_new", oDATA, 16'h0077);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) fifo_write(N'($urandom));
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);

    // Asynchronous reset between clock edges with two words held.
    fifo_write(16'h0D00);
    fifo_write(16'h0D01);
    fifo_write(16'h0D02);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    check("ar_hold2", oHOLD_COUNT, 2'd2);
    #2;
    inRESET = 1'b0;
    #1;
    check("ar_req",  oREQ,        1'b0);
    check("ar_hold", oHOLD_COUNT, 2'd0);
    check("ar_data", oDATA,       16'h0000);
    model_reset();
    drive_fifo();
    @(negedge iCLOCK);
    inRESET = 1'b1;
    fifo_write(16'h0E00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
